// File: rtl/keycode_pkg.sv
// Shared types and helpers for the keycode event decoder.
// Event encodings, HID key codes and the game-key lookup.
package keycode_pkg;

    localparam logic [7:0] KEY_JUMP_HID    = 8'h2C;
    localparam logic [7:0] KEY_PAUSE_HID   = 8'h13;
    localparam logic [7:0] KEY_RESTART_HID = 8'h15;

    typedef enum logic [1:0] {
        EVT_JUMP    = 2'd0,
        EVT_PAUSE   = 2'd1,
        EVT_RESTART = 2'd2
    } evt_code_t;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_REPEAT  = 2'd2
    } evt_type_t;

    typedef struct packed {
        evt_code_t code;
        evt_type_t kind;
    } evt_t;

    typedef struct packed {
        logic      valid;
        evt_code_t code;
    } key_map_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EMIT_REL = 2'd1,
        ST_EMIT_PRS = 2'd2
    } fsm_t;

    function automatic key_map_t map_key(
        input logic [7:0] code,
        input logic [7:0] k_jump,
        input logic [7:0] k_pause,
        input logic [7:0] k_restart
    );
        key_map_t m;
        m.valid = 1'b1;
        m.code  = EVT_JUMP;
        if (code == k_jump) begin
            m.code = EVT_JUMP;
        end else if (code == k_pause) begin
            m.code = EVT_PAUSE;
        end else if (code == k_restart) begin
            m.code = EVT_RESTART;
        end else begin
            m.valid = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/keycode_event_decoder_fifo.sv
// Small registered event FIFO, no fall-through.
// Drops pushes while full unless a pop frees a slot the same cycle.
import keycode_pkg::*;

module evt_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = evt_t
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  T     i_data,
    input  logic i_ready,
    output logic o_valid,
    output T     o_data,
    output logic o_overflow
);

    localparam int AW = $clog2(DEPTH);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_count;
    logic           r_overflow;
    logic           w_full;
    logic           w_pop;
    logic           w_wr;

    assign o_valid    = (r_count != '0);
    assign w_full     = (r_count == (AW+1)'(DEPTH));
    assign w_pop      = o_valid && i_ready;
    assign w_wr       = i_push && (!w_full || w_pop);
    assign o_data     = r_mem[r_rptr];
    assign o_overflow = r_overflow;

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && !w_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/keycode_event_decoder.sv
// Debounces the NIOS keycode and turns changes into game-key events.
// RELEASE of the old key always precedes PRESS of the new one.
import keycode_pkg::*;

module keycode_event_decoder #(
    parameter int         STABLE_CYCLES = 4,
    parameter int         FIFO_DEPTH    = 4,
    parameter int         REPEAT_DELAY  = 30,
    parameter int         REPEAT_RATE   = 6,
    parameter logic [7:0] KEY_JUMP      = KEY_JUMP_HID,
    parameter logic [7:0] KEY_PAUSE     = KEY_PAUSE_HID,
    parameter logic [7:0] KEY_RESTART   = KEY_RESTART_HID
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_code,
    output logic [1:0] evt_type,
    output logic       held_jump,
    output logic       held_pause,
    output logic       held_restart,
    output logic [7:0] stable_keycode,
    output logic       overflow
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int RW = $clog2(REPEAT_DELAY + 1);

    logic [7:0]    r_kc_s1;
    logic [7:0]    r_kc_s2;
    logic [7:0]    r_cand;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_stable;
    logic [7:0]    r_prev;
    logic [7:0]    r_next;
    logic [RW-1:0] r_rcnt;
    fsm_t          r_state;
    fsm_t          w_next_state;
    logic          w_cnt_max;
    logic          w_commit;
    logic          w_rep_act;
    logic          w_rep_fire;
    logic          w_push;
    evt_t          w_push_evt;
    evt_t          w_head;
    key_map_t      w_old_map;
    key_map_t      w_new_map;
    key_map_t      w_prev_map;
    key_map_t      w_next_map;

    assign w_cnt_max  = (r_cnt == CW'(STABLE_CYCLES - 1));
    assign w_commit   = w_cnt_max && (r_cand != r_stable) && (r_state == ST_IDLE);
    assign w_rep_act  = (r_stable == KEY_JUMP) && (r_state == ST_IDLE) && !w_commit;
    assign w_rep_fire = w_rep_act && frame_tick && (r_rcnt == RW'(REPEAT_DELAY - 1));

    assign w_old_map  = map_key(r_stable, KEY_JUMP, KEY_PAUSE, KEY_RESTART);
    assign w_new_map  = map_key(r_cand, KEY_JUMP, KEY_PAUSE, KEY_RESTART);
    assign w_prev_map = map_key(r_prev, KEY_JUMP, KEY_PAUSE, KEY_RESTART);
    assign w_next_map = map_key(r_next, KEY_JUMP, KEY_PAUSE, KEY_RESTART);

    assign stable_keycode = r_stable;
    assign held_jump      = (r_stable == KEY_JUMP);
    assign held_pause     = (r_stable == KEY_PAUSE);
    assign held_restart   = (r_stable == KEY_RESTART);
    assign evt_code       = w_head.code;
    assign evt_type       = w_head.kind;

    // Two-flop synchroniser followed by the stability counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_kc_s1 <= '0;
            r_kc_s2 <= '0;
            r_cand  <= '0;
            r_cnt   <= '0;
        end else begin
            r_kc_s1 <= keycode;
            r_kc_s2 <= r_kc_s1;
            if (r_kc_s2 != r_cand) begin
                r_cand <= r_kc_s2;
                r_cnt  <= '0;
            end else if (!w_cnt_max) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Commit the debounced code and remember the old/new pair to report.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stable <= '0;
            r_prev   <= '0;
            r_next   <= '0;
        end else if (w_commit) begin
            r_stable <= r_cand;
            r_prev   <= r_stable;
            r_next   <= r_cand;
        end
    end

    // Auto-repeat tick counter; ticks during commits or emits are lost.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rcnt <= '0;
        end else if (w_commit) begin
            r_rcnt <= '0;
        end else if (w_rep_act && frame_tick) begin
            if (w_rep_fire) begin
                r_rcnt <= RW'(REPEAT_DELAY - REPEAT_RATE);
            end else begin
                r_rcnt <= r_rcnt + RW'(1);
            end
        end
    end

    // Emit FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and the single FIFO push per cycle.
    always_comb begin
        w_next_state    = r_state;
        w_push          = 1'b0;
        w_push_evt.code = EVT_JUMP;
        w_push_evt.kind = EVT_REPEAT;
        unique case (r_state)
            ST_IDLE: begin
                if (w_commit) begin
                    if (w_old_map.valid) begin
                        w_next_state = ST_EMIT_REL;
                    end else if (w_new_map.valid) begin
                        w_next_state = ST_EMIT_PRS;
                    end
                end else if (w_rep_fire) begin
                    w_push = 1'b1;
                end
            end
            ST_EMIT_REL: begin
                w_push          = 1'b1;
                w_push_evt.code = w_prev_map.code;
                w_push_evt.kind = EVT_RELEASE;
                w_next_state    = w_next_map.valid ? ST_EMIT_PRS : ST_IDLE;
            end
            ST_EMIT_PRS: begin
                w_push          = 1'b1;
                w_push_evt.code = w_next_map.code;
                w_push_evt.kind = EVT_PRESS;
                w_next_state    = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (evt_t)
    ) u_fifo (
        .i_clk      (Clk),
        .i_rst      (Reset),
        .i_push     (w_push),
        .i_data     (w_push_evt),
        .i_ready    (evt_ready),
        .o_valid    (evt_valid),
        .o_data     (w_head),
        .o_overflow (overflow)
    );

endmodule

// File: tb/tb_keycode_event_decoder.sv
// Bench for keycode_event_decoder: directed scenarios plus random
// key/tick traffic checked against an event-level reference model.
module tb_keycode_event_decoder;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic       frame_tick = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic [1:0] evt_type;
    logic       held_jump;
    logic       held_pause;
    logic       held_restart;
    logic [7:0] stable_keycode;
    logic       overflow;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] exp_q [$];
    logic [3:0] mon_e;
    logic [7:0] m_stable;
    int         m_rcnt;
    bit         m_ovf;
    bit         rnd_ready = 1'b0;
    bit         mon_en = 1'b1;

    always #5 Clk = ~Clk;

    keycode_event_decoder dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .keycode        (keycode),
        .frame_tick     (frame_tick),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_code       (evt_code),
        .evt_type       (evt_type),
        .held_jump      (held_jump),
        .held_pause     (held_pause),
        .held_restart   (held_restart),
        .stable_keycode (stable_keycode),
        .overflow       (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Game-key index of a HID code, -1 when not a game key.
    function automatic int key_of(input logic [7:0] c);
        if (c == 8'h2C) return 0;
        if (c == 8'h13) return 1;
        if (c == 8'h15) return 2;
        return -1;
    endfunction

    task automatic m_push(input int c, input int t);
        if (exp_q.size() >= 4) m_ovf = 1'b1;
        else exp_q.push_back({2'(c), 2'(t)});
    endtask

    task automatic m_reset();
        exp_q.delete();
        m_stable = 8'h00;
        m_rcnt   = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic m_set(input logic [7:0] c);
        int kp, kn;
        if (c != m_stable) begin
            kp = key_of(m_stable);
            kn = key_of(c);
            if (kp >= 0) m_push(kp, 1);
            if (kn >= 0) m_push(kn, 0);
            m_stable = c;
            m_rcnt   = 0;
        end
    endtask

    task automatic m_tick();
        if (m_stable == 8'h2C) begin
            m_rcnt++;
            if (m_rcnt == 30) begin
                m_push(0, 2);
                m_rcnt = 24;
            end
        end
    endtask

    task automatic cyc(input bit tick);
        frame_tick = tick;
        if (tick) m_tick();
        if (rnd_ready) evt_ready = ($urandom_range(3) != 0);
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0);
    endtask

    task automatic hold(input logic [7:0] c, input int n);
        keycode = c;
        m_set(c);
        idle(n);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(5))
            0:       return 8'h00;
            1:       return 8'h2C;
            2:       return 8'h13;
            3:       return 8'h15;
            4:       return 8'h04;
            default: return 8'($urandom_range(255));
        endcase
    endfunction

    // Every accepted head must match the oldest expected event.
    always @(negedge Clk) begin
        if (mon_en && !Reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_evt", {28'h0, evt_code, evt_type}, 32'hF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("evt_head", {28'h0, evt_code, evt_type}, {28'h0, mon_e});
            end
        end
    end

    initial begin
        logic [7:0] g, old;
        int n;
        m_reset();
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_valid", evt_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_stable", stable_keycode, 0);
        chk("rst_held", {held_jump, held_pause, held_restart}, 0);

        Reset     = 1'b0;
        keycode   = 8'h2C;
        evt_ready = 1'b1;
        m_set(8'h2C);
        for (int k = 1; k <= 8; k++) begin
            @(posedge Clk);
            #1;
            chk("lat_valid", evt_valid, (k == 8));
        end
        chk("lat_held_jump", held_jump, 1);
        chk("lat_stable", stable_keycode, 8'h2C);
        idle(5);

        keycode = 8'h13;
        m_set(8'h13);
        for (int k = 1; k <= 10; k++) begin
            @(posedge Clk);
            #1;
            chk("k2k_valid", evt_valid, (k == 8 || k == 9));
        end
        chk("k2k_held", {held_jump, held_pause, held_restart}, 3'b010);

        hold(8'h00, 14);
        keycode = 8'h15;
        idle(2);
        keycode = 8'h00;
        idle(12);
        chk("glitch_stable", stable_keycode, 0);
        chk("glitch_valid", evt_valid, 0);
        chk("glitch_pending", exp_q.size(), 0);

        hold(8'h2C, 14);
        chk("rep_press_seen", exp_q.size(), 0);
        evt_ready = 1'b0;
        for (int t = 1; t <= 36; t++) begin
            cyc(1'b1);
            idle(9);
            if (t == 29 || t == 35) chk("rep_early", evt_valid, 0);
            if (t == 30 || t == 36) begin
                chk("rep_due", evt_valid, 1);
                evt_ready = 1'b1;
                idle(2);
                evt_ready = 1'b0;
                chk("rep_drain", exp_q.size(), 0);
            end
        end
        evt_ready = 1'b1;
        hold(8'h00, 14);
        for (int t = 0; t < 40; t++) cyc(t % 3 == 0);
        chk("rep_stop_valid", evt_valid, 0);
        chk("rep_stop_pending", exp_q.size(), 0);

        evt_ready = 1'b0;
        repeat (3) begin
            hold(8'h13, 12);
            hold(8'h00, 12);
        end
        chk("ovf_set", overflow, 1);
        chk("ovf_valid", evt_valid, 1);
        evt_ready = 1'b1;
        idle(8);
        chk("ovf_drain", exp_q.size(), 0);
        chk("ovf_empty", evt_valid, 0);
        chk("ovf_sticky", overflow, 1);
        Reset = 1'b1;
        idle(2);
        Reset = 1'b0;
        m_reset();
        chk("ovf_rst_ovf", overflow, 0);
        chk("ovf_rst_valid", evt_valid, 0);

        hold(8'h2C, 14);
        keycode = 8'h13;
        repeat (7) @(posedge Clk);
        #1;
        chk("rrel_pre_valid", evt_valid, 0);
        chk("rrel_pre_stable", stable_keycode, 8'h13);
        Reset   = 1'b1;
        keycode = 8'h00;
        @(posedge Clk);
        #1;
        chk("rrel_valid", evt_valid, 0);
        chk("rrel_stable", stable_keycode, 0);
        Reset = 1'b0;
        m_reset();
        idle(14);
        chk("rrel_no_press", evt_valid, 0);

        rnd_ready = 1'b1;
        repeat (60) begin
            case ($urandom_range(9))
                0, 1, 2, 3, 4: hold(pick(), $urandom_range(12, 20));
                5, 6: begin
                    g = pick();
                    if (g != keycode) begin
                        old     = keycode;
                        keycode = g;
                        idle($urandom_range(1, 2));
                        keycode = old;
                        idle(12);
                    end
                end
                default: begin
                    n = $urandom_range(20, 200);
                    for (int i = 0; i < n; i++) cyc($urandom_range(3) == 0);
                end
            endcase
        end
        rnd_ready = 1'b0;
        evt_ready = 1'b1;
        idle(10);
        chk("rnd_pending", exp_q.size(), 0);
        chk("rnd_ovf", overflow, m_ovf);
        chk("rnd_stable", stable_keycode, m_stable);
        chk("rnd_held_jump", held_jump, (m_stable == 8'h2C));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
